// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx -- PS/2 keyboard receiver with scan-code decoding and an event FIFO.
//
// This block synchronises and de-glitches the raw PS/2 clock. It receives
// 11-bit frames on the falling edges of the filtered clock: start, 8 data
// bits LSB first, odd parity, stop. It folds the 0xE0/0xF0 prefixes into a
// single event {keyup, extend, code}. It can drop an event that repeats the
// previous one. It queues events in a first-word fall-through FIFO.
//
// Ports
//   clk, rst     system clock; asynchronous active-high reset
//   ps2_clk      raw PS/2 clock (asynchronous)
//   ps2_data     raw PS/2 data (asynchronous)
//   rd_en        pop the head entry (ignored while empty)
//   clr_err      clear overflow / parity_err / frame_err
//   keyup        head entry break flag
//   extend       head entry E0 flag
//   scancode     head entry code
//   valid        FIFO not empty
//   level        number of stored entries (0 .. 2^FIFO_AW)
//   overflow     sticky: an event was dropped because the FIFO was full
//   parity_err   sticky: a frame failed its parity check
//   frame_err    sticky: a bad stop bit or an inter-edge timeout occurred
module ps2_kbd_rx #(
  parameter int FIFO_AW  = 4,
  parameter int FILT_LEN = 4,
  parameter int TIMEOUT  = 50000,
  parameter int DEDUP    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  input  logic               rd_en,
  input  logic               clr_err,
  output logic               keyup,
  output logic               extend,
  output logic [7:0]         scancode,
  output logic               valid,
  output logic [FIFO_AW:0]   level,
  output logic               overflow,
  output logic               parity_err,
  output logic               frame_err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int FCW   = $clog2(FILT_LEN + 1);
  localparam int TCW   = $clog2(TIMEOUT + 1);
  localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_STOP  = 2'd2;

  // Control state (asynchronously reset)
  logic               clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic               dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic               filt_clk_q, filt_clk_d;
  logic [FCW-1:0]     filt_cnt_q, filt_cnt_d;
  logic [1:0]         state_q, state_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [TCW-1:0]     to_cnt_q, to_cnt_d;
  logic               resync_q, resync_d;
  logic               pend_up_q, pend_up_d, pend_ext_q, pend_ext_d;
  logic [9:0]         last_evt_q, last_evt_d;
  logic               push_q, push_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               ovf_q, ovf_d, perr_q, perr_d, ferr_q, ferr_d;

  // Datapath state (no reset needed)
  logic [8:0]         sr_q, sr_d;
  logic [9:0]         evt_q, evt_d;
  logic [9:0]         mem_q [DEPTH];

  logic               samp, to_hit, set_perr, set_ferr;
  logic               pop, full, wr_en, ovf_set;
  logic [9:0]         cand;

  always_comb begin
    // Two-flop synchronisers
    clk_s1_d = ps2_clk;
    clk_s2_d = clk_s1_q;
    dat_s1_d = ps2_data;
    dat_s2_d = dat_s1_q;

    // Glitch filter: the filtered clock follows only after FILT_LEN
    // consecutive disagreeing samples. A 1->0 flip is a sample event.
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    samp       = 1'b0;
    if (clk_s2_q != filt_clk_q) begin
      if (filt_cnt_q == FCW'(FILT_LEN - 1)) begin
        filt_clk_d = clk_s2_q;
        samp       = filt_clk_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FCW'(1);
      end
    end

    // Frame receiver
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    to_cnt_d   = '0;
    resync_d   = resync_q;
    pend_up_d  = pend_up_q;
    pend_ext_d = pend_ext_q;
    last_evt_d = last_evt_q;
    push_d     = 1'b0;
    evt_d      = evt_q;
    sr_d       = sr_q;
    set_perr   = 1'b0;
    set_ferr   = 1'b0;
    cand       = {pend_up_q, pend_ext_q, sr_q[7:0]};
    to_hit     = (to_cnt_q == TCW'(TIMEOUT - 1));

    case (state_q)
      ST_IDLE: begin
        // After reset the line may be mid-frame. Start bits are only
        // trusted once the clock has been quiet for a full timeout.
        if (resync_q) begin
          if (samp)        to_cnt_d = '0;
          else if (to_hit) resync_d = 1'b0;
          else             to_cnt_d = to_cnt_q + TCW'(1);
        end else if (samp && !dat_s2_q) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = 4'd0;
        end
      end
      ST_SHIFT, ST_STOP: begin
        if (samp) begin
          if (state_q == ST_SHIFT) begin
            sr_d = {dat_s2_q, sr_q[8:1]};
            if (bit_cnt_q == 4'd8) state_d = ST_STOP;
            else                   bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            state_d = ST_IDLE;
            if (!dat_s2_q) begin
              set_ferr   = 1'b1;
              pend_up_d  = 1'b0;
              pend_ext_d = 1'b0;
            end else if (!(^sr_q)) begin
              // Odd parity: data plus parity must hold an odd number of ones
              set_perr   = 1'b1;
              pend_up_d  = 1'b0;
              pend_ext_d = 1'b0;
            end else if (sr_q[7:0] == 8'hF0) begin
              pend_up_d  = 1'b1;
            end else if (sr_q[7:0] == 8'hE0) begin
              pend_ext_d = 1'b1;
            end else begin
              pend_up_d  = 1'b0;
              pend_ext_d = 1'b0;
              last_evt_d = cand;
              if (!(DEDUP != 0 && cand == last_evt_q)) begin
                push_d = 1'b1;
                evt_d  = cand;
              end
            end
          end
        end else if (to_hit) begin
          state_d    = ST_IDLE;
          bit_cnt_d  = 4'd0;
          set_ferr   = 1'b1;
          pend_up_d  = 1'b0;
          pend_ext_d = 1'b0;
        end else begin
          to_cnt_d = to_cnt_q + TCW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // FIFO: a push into a full FIFO only succeeds when a pop frees the slot
    pop      = rd_en && (level_q != '0);
    full     = (level_q == FULL_LVL);
    wr_en    = push_q && (!full || pop);
    ovf_set  = push_q && full && !pop;
    wr_ptr_d = wr_en ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    level_d  = level_q + (FIFO_AW + 1)'(wr_en) - (FIFO_AW + 1)'(pop);

    // Sticky flags: a new error wins over a simultaneous clear
    ovf_d  = (clr_err ? 1'b0 : ovf_q)  | ovf_set;
    perr_d = (clr_err ? 1'b0 : perr_q) | set_perr;
    ferr_d = (clr_err ? 1'b0 : ferr_q) | set_ferr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_clk_q <= 1'b1;
      filt_cnt_q <= '0;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      to_cnt_q   <= '0;
      resync_q   <= 1'b1;
      pend_up_q  <= 1'b0;
      pend_ext_q <= 1'b0;
      last_evt_q <= 10'h000;
      push_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      filt_clk_q <= filt_clk_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      to_cnt_q   <= to_cnt_d;
      resync_q   <= resync_d;
      pend_up_q  <= pend_up_d;
      pend_ext_q <= pend_ext_d;
      last_evt_q <= last_evt_d;
      push_q     <= push_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  always_ff @(posedge clk) begin
    sr_q  <= sr_d;
    evt_q <= evt_d;
    if (wr_en) mem_q[wr_ptr_q] <= evt_q;
  end

  assign {keyup, extend, scancode} = mem_q[rd_ptr_q];
  assign valid      = (level_q != '0);
  assign level      = level_q;
  assign overflow   = ovf_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Testbench for ps2_kbd_rx. Three instances share one PS/2 line:
//   dut_a: FIFO_AW=4, DEDUP=1; dut_b: FIFO_AW=4, DEDUP=0; dut_c: FIFO_AW=1, DEDUP=1.
module tb_ps2_kbd_rx;
  localparam int TO = 300;

  logic clk = 1'b0;
  logic rst, ps2_clk, ps2_data, clr_err;
  logic rd_a, rd_b, rd_c;

  logic       keyup_a, extend_a, valid_a, ovf_a, perr_a, ferr_a;
  logic [7:0] code_a;
  logic [4:0] level_a;
  logic       keyup_b, extend_b, valid_b, ovf_b, perr_b, ferr_b;
  logic [7:0] code_b;
  logic [4:0] level_b;
  logic       keyup_c, extend_c, valid_c, ovf_c, perr_c, ferr_c;
  logic [7:0] code_c;
  logic [1:0] level_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ps2_kbd_rx #(.FIFO_AW(4), .FILT_LEN(4), .TIMEOUT(TO), .DEDUP(1)) dut_a (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_a), .clr_err(clr_err), .keyup(keyup_a), .extend(extend_a),
    .scancode(code_a), .valid(valid_a), .level(level_a), .overflow(ovf_a),
    .parity_err(perr_a), .frame_err(ferr_a));

  ps2_kbd_rx #(.FIFO_AW(4), .FILT_LEN(4), .TIMEOUT(TO), .DEDUP(0)) dut_b (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_b), .clr_err(clr_err), .keyup(keyup_b), .extend(extend_b),
    .scancode(code_b), .valid(valid_b), .level(level_b), .overflow(ovf_b),
    .parity_err(perr_b), .frame_err(ferr_b));

  ps2_kbd_rx #(.FIFO_AW(1), .FILT_LEN(4), .TIMEOUT(TO), .DEDUP(1)) dut_c (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_c), .clr_err(clr_err), .keyup(keyup_c), .extend(extend_c),
    .scancode(code_c), .valid(valid_c), .level(level_c), .overflow(ovf_c),
    .parity_err(perr_c), .frame_err(ferr_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One PS/2 bit: data set mid-high, 20-cycle low phase. With pop_c set,
  // rd_c is high for exactly the cycle in which the receiver pushes the
  // event. That cycle is the one after the filtered sample, which comes
  // 2 sync + 4 filter cycles after the fall.
  task automatic ps2_bit(input logic b, input bit pop_c);
    @(negedge clk) ps2_data = b;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (pop_c && k == 6) rd_c = 1'b1;
      if (k == 7) rd_c = 1'b0;
    end
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit bad_par, input bit pop_c);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
    ps2_bit((~^b) ^ bad_par, 1'b0);
    ps2_bit(1'b1, pop_c);
    repeat (20) @(negedge clk);
  endtask

  task automatic pop(input bit a, input bit bb, input bit c);
    @(negedge clk);
    rd_a = a; rd_b = bb; rd_c = c;
    @(negedge clk);
    rd_a = 1'b0; rd_b = 1'b0; rd_c = 1'b0;
  endtask

  task automatic clear_err();
    @(negedge clk) clr_err = 1'b1;
    @(negedge clk) clr_err = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; clr_err = 1'b0;
    rd_a = 1'b0; rd_b = 1'b0; rd_c = 1'b0;
    #1 rst = 1'b1;
    #1;
    // Asynchronous reset takes effect before any clock edge
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_level", 32'(level_a), 32'd0);
    chk("rst_flags", {29'd0, ovf_a, perr_a, ferr_a}, 32'd0);
    chk("rst_level_c", 32'(level_c), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (TO + 100) @(negedge clk);

    // Single good frame, then pop
    send(8'h1C, 1'b0, 1'b0);
    chk("one_valid", 32'(valid_a), 32'd1);
    chk("one_head", 32'({keyup_a, extend_a, code_a}), 32'h01C);
    chk("one_level", 32'(level_a), 32'd1);
    pop(1, 1, 1);
    chk("pop_valid", 32'(valid_a), 32'd0);
    chk("pop_level", 32'(level_a), 32'd0);

    // Extended break sequence
    send(8'hE0, 1'b0, 1'b0);
    send(8'hF0, 1'b0, 1'b0);
    send(8'h75, 1'b0, 1'b0);
    chk("ext_level", 32'(level_a), 32'd1);
    chk("ext_head", 32'({keyup_a, extend_a, code_a}), 32'h375);
    pop(1, 1, 1);

    // Repeat suppression
    send(8'h1C, 1'b0, 1'b0);
    send(8'h1C, 1'b0, 1'b0);
    send(8'hF0, 1'b0, 1'b0);
    send(8'h1C, 1'b0, 1'b0);
    chk("dedup_level", 32'(level_a), 32'd2);
    chk("dedup_head0", 32'({keyup_a, extend_a, code_a}), 32'h01C);
    chk("nodedup_level", 32'(level_b), 32'd3);
    pop(1, 0, 0);
    chk("dedup_head1", 32'({keyup_a, extend_a, code_a}), 32'h21C);
    repeat (3) pop(1, 1, 1);

    // Parity error, recovery, clear
    send(8'h1C, 1'b1, 1'b0);
    chk("perr_set", 32'(perr_a), 32'd1);
    chk("perr_noframe", 32'(ferr_a), 32'd0);
    chk("perr_level", 32'(level_a), 32'd0);
    send(8'h1C, 1'b0, 1'b0);
    chk("perr_recover_lvl", 32'(level_a), 32'd1);
    chk("perr_recover_head", 32'({keyup_a, extend_a, code_a}), 32'h01C);
    clear_err();
    chk("perr_clear", 32'(perr_a), 32'd0);
    repeat (2) pop(1, 1, 1);

    // Overflow on the 2-deep FIFO
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0);
    chk("ovf_level_c", 32'(level_c), 32'd2);
    chk("ovf_flag_c", 32'(ovf_c), 32'd1);
    chk("ovf_head_c", 32'({keyup_c, extend_c, code_c}), 32'h011);
    chk("deep_level_a", 32'(level_a), 32'd3);
    chk("deep_ovf_a", 32'(ovf_a), 32'd0);
    clear_err();
    chk("ovf_clear_c", 32'(ovf_c), 32'd0);

    // Push and pop together while full
    send(8'h44, 1'b0, 1'b1);
    chk("fullpp_level_c", 32'(level_c), 32'd2);
    chk("fullpp_ovf_c", 32'(ovf_c), 32'd0);
    chk("fullpp_head_c", 32'({keyup_c, extend_c, code_c}), 32'h022);
    pop(0, 0, 1);
    chk("fullpp_tail_c", 32'({keyup_c, extend_c, code_c}), 32'h044);
    chk("fullpp_lvl1_c", 32'(level_c), 32'd1);
    chk("fullpp_level_a", 32'(level_a), 32'd4);

    // Truncated frame -> timeout
    repeat (5) pop(1, 1, 1);
    clear_err();
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_data = 1'b1;
    repeat (TO / 2) @(negedge clk);
    chk("to_early", 32'(ferr_a), 32'd0);
    repeat (TO) @(negedge clk);
    chk("to_ferr", 32'(ferr_a), 32'd1);
    chk("to_level", 32'(level_a), 32'd0);
    send(8'h55, 1'b0, 1'b0);
    chk("to_recover_lvl", 32'(level_a), 32'd1);
    chk("to_recover_head", 32'({keyup_a, extend_a, code_a}), 32'h055);
    chk("to_no_perr", 32'(perr_a), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
